// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer controller.
package countdown_timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } t_timer_state;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] BCD_ZERO      = 8'h00;
  localparam logic [3:0] RELOAD_MAX    = 4'd15;

endpackage

// File: rtl/countdown_timer_ctrl_clamp.sv
// bcd_clamp_digit: clamps a 4-bit nibble into the legal BCD range 0..9.
module bcd_clamp_digit
  import countdown_timer_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Non-BCD codes (A..F) saturate to 9 rather than wrapping.
  assign dout = (din > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : din;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: sequencing FSM for a two-digit BCD down-counter.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (auto reload after expiry).
module countdown_timer_ctrl
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       stop_p,
  input  logic [7:0] preset,
  input  logic [7:0] cnt_value,
  input  logic       cnt_tc,
  output logic       cnt_loadN,
  output logic       cnt_ena,
  output logic       cnt_ena_cnt,
  output logic [7:0] cnt_init,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic [3:0] reload_cnt
);

  t_timer_state state, next_state;
  logic [7:0]   preset_clamped;
  logic         at_zero;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic         auto_reload;
`endif

  bcd_clamp_digit u_clamp_tens (.din(preset[7:4]), .dout(preset_clamped[7:4]));
  bcd_clamp_digit u_clamp_ones (.din(preset[3:0]), .dout(preset_clamped[3:0]));

  // Expiry on the terminal-count flag, backed up by the count value itself.
  assign at_zero = cnt_tc || (cnt_value == BCD_ZERO);

  // Count strobe stays combinational so a tick is counted in its own cycle.
  assign cnt_ena_cnt = (state == S_RUN) && tick && !cnt_tc;

  // Next-state logic: stop beats start beats pause, then state-local moves.
  always_comb begin
    next_state = state;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    auto_reload = 1'b0;
`endif
    if (stop_p) begin
      next_state = S_IDLE;
    end else if (start_p) begin
      next_state = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  next_state = S_IDLE;
        S_LOAD:  next_state = S_RUN;
        S_RUN: begin
          if (pause_p)      next_state = S_PAUSE;
          else if (at_zero) next_state = S_EXPIRED;
        end
        S_PAUSE: if (pause_p) next_state = S_RUN;
        S_EXPIRED: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          next_state  = S_LOAD;
          auto_reload = 1'b1;
`else
          next_state  = S_EXPIRED;
`endif
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State register and registered strobes, decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt_loadN <= 1'b1;
      cnt_ena   <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      expired   <= 1'b0;
      cnt_init  <= BCD_ZERO;
    end else begin
      state     <= next_state;
      cnt_loadN <= (next_state != S_LOAD);
      cnt_ena   <= (next_state == S_LOAD) || (next_state == S_RUN) ||
                   (next_state == S_PAUSE);
      running   <= (next_state == S_RUN);
      paused    <= (next_state == S_PAUSE);
      expired   <= (next_state == S_EXPIRED) && (state != S_EXPIRED);
      if (start_p && !stop_p)
        cnt_init <= preset_clamped;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Auto-reload counter: cleared by user commands, saturates at RELOAD_MAX.
  always_ff @(posedge clk) begin
    if (reset)
      reload_cnt <= 4'd0;
    else if (stop_p || start_p)
      reload_cnt <= 4'd0;
    else if (auto_reload && (reload_cnt != RELOAD_MAX))
      reload_cnt <= reload_cnt + 4'd1;
  end
`else
  assign reload_cnt = 4'd0;
`endif

endmodule
